// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter between two byte requesters feeding one 8N1 UART transmitter.
// Latency: start bit appears one cycle after the handshake; backpressure: both readies stay low for the whole frame.
module ser_tx_arbiter #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUDRATE = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [7:0] req1_data_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    output logic       ser_tx_o,
    output logic       busy_o,
    output logic       grant_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             grant_q, grant_d;
    logic             prio_q, prio_d;
    logic             tx_q, tx_d;
    logic             sel;
    logic             hs;
    logic             bit_done;

    // Readies are gated by rst_i so they are low during reset even before the first edge.
    always_comb begin
        sel          = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
        req0_ready_o = !rst_i && (state_q == IDLE) && req0_valid_i && !sel;
        req1_ready_o = !rst_i && (state_q == IDLE) && req1_valid_i && sel;
        hs           = req0_ready_o || req1_ready_o;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        tx_d      = 1'b1;
        bit_done  = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hs) begin
                    data_d    = sel ? req1_data_i : req0_data_i;
                    grant_d   = sel;
                    prio_d    = !sel;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = data_q[bit_idx_q];
                if (bit_done) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            tx_q      <= tx_d;
        end
    end

    assign ser_tx_o = tx_q;
    assign busy_o   = (state_q != IDLE);
    assign grant_o  = grant_q;

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Randomized bench for ser_tx_arbiter at 4 and 3 clocks per bit, checked against a frame-level model.
module tb_ser_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       r0, r1, tx, busy, grant;
    logic [7:0] d0_3 = '0, d1_3 = '0;
    logic       v0_3 = 1'b0, v1_3 = 1'b0;
    logic       r0_3, r1_3, tx3, busy3, grant3;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int mprio     = 0;

    always #5 clk = ~clk;

    ser_tx_arbiter #(.CLK_FREQ(1_000_000), .BAUDRATE(250_000)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_data_i(d0), .req0_valid_i(v0), .req0_ready_o(r0),
        .req1_data_i(d1), .req1_valid_i(v1), .req1_ready_o(r1),
        .ser_tx_o(tx), .busy_o(busy), .grant_o(grant)
    );

    ser_tx_arbiter #(.CLK_FREQ(1_000_000), .BAUDRATE(300_000)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .req0_data_i(d0_3), .req0_valid_i(v0_3), .req0_ready_o(r0_3),
        .req1_data_i(d1_3), .req1_valid_i(v1_3), .req1_ready_o(r1_3),
        .ser_tx_o(tx3), .busy_o(busy3), .grant_o(grant3)
    );

    // Expected line level for each cycle of a frame: start, 8 data LSB first, stop.
    function automatic logic [39:0] exp_wave(input logic [7:0] b, input int cpb);
        logic [9:0]  fr;
        logic [39:0] w;
        fr = {1'b1, b, 1'b0};
        w  = '0;
        for (int k = 0; k < 10 * cpb; k++) w[k] = fr[k / cpb];
        return w;
    endfunction

    function automatic logic [39:0] ones(input int n);
        logic [39:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k] = 1'b1;
        return w;
    endfunction

    // UART receiver: sample each data bit in the middle of its bit period.
    function automatic logic [7:0] decode(input logic [39:0] v, input int cpb);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = v[(i + 1) * cpb + cpb / 2];
        return b;
    endfunction

    task automatic do_handshake(input bit d3, output int who, output int w, output bit ok);
        ok  = 1'b0;
        who = -1;
        w   = 0;
        #1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (d3) begin
                if (r0_3 && v0_3) begin who = 0; ok = 1'b1; end
                else if (r1_3 && v1_3) begin who = 1; ok = 1'b1; end
            end else begin
                if (r0 && v0) begin who = 0; ok = 1'b1; end
                else if (r1 && v1) begin who = 1; ok = 1'b1; end
            end
            if (!ok) begin
                w++;
                @(negedge clk);
            end
        end
        if (ok) @(posedge clk);
    endtask

    // Called just after the handshake edge N: busy sampled after N..N+10cpb, line after N+1..N+10cpb.
    task automatic capture(input bit d3, input int cpb, output logic [39:0] txv,
                           output logic [39:0] bsv, output logic busy_end, output logic rdy_seen);
        txv      = '0;
        bsv      = '0;
        rdy_seen = 1'b0;
        busy_end = 1'b0;
        for (int k = 0; k <= 10 * cpb; k++) begin
            @(negedge clk);
            if (k < 10 * cpb) begin
                bsv[k]   = d3 ? busy3 : busy;
                rdy_seen = rdy_seen | (d3 ? (r0_3 | r1_3) : (r0 | r1));
            end else begin
                busy_end = d3 ? busy3 : busy;
            end
            if (k >= 1) txv[k - 1] = d3 ? tx3 : tx;
        end
    endtask

    task automatic test_reset();
        v0 = 1'b1; v1 = 1'b1;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if ({r0, r1} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {r0, r1}); else pass_cnt++;
        total_cnt++; if (grant !== 1'b0) $display("FAIL rst_grant: got %b want 0", grant); else pass_cnt++;
        total_cnt++; if (tx3 !== 1'b1) $display("FAIL rst_tx3: got %b want 1", tx3); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if ({r0, r1, busy, tx} !== 4'b0001) $display("FAIL rst_clocked: got %b want 0001", {r0, r1, busy, tx}); else pass_cnt++;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_single();
        int who, w; bit ok;
        logic [39:0] txv, bsv; logic be, rs;
        @(posedge clk); #1 rst = 1'b0; mprio = 0;
        d0 = 8'h55; v0 = 1'b1;
        do_handshake(1'b0, who, w, ok);
        total_cnt++; if (!ok || who != 0 || w != 0) $display("FAIL single_hs: got ok=%0d who=%0d wait=%0d want 1/0/0", ok, who, w); else pass_cnt++;
        #1 v0 = 1'b0;
        capture(1'b0, 4, txv, bsv, be, rs);
        mprio = 1;
        total_cnt++; if (txv !== exp_wave(8'h55, 4)) $display("FAIL single_wave: got %h want %h", txv, exp_wave(8'h55, 4)); else pass_cnt++;
        total_cnt++; if (bsv !== ones(40) || be !== 1'b0) $display("FAIL single_busy: got %h/%b want %h/0", bsv, be, ones(40)); else pass_cnt++;
        total_cnt++; if (rs !== 1'b0) $display("FAIL single_ready_in_frame: got %b want 0", rs); else pass_cnt++;
        total_cnt++; if (grant !== 1'b0) $display("FAIL single_grant: got %b want 0", grant); else pass_cnt++;
    endtask

    task automatic test_contention();
        int who, w; bit ok; time t1, t2;
        logic [39:0] txv, bsv; logic be, rs;
        @(posedge clk); #1 rst = 1'b1;
        d0 = 8'hA1; d1 = 8'hB2; v0 = 1'b1; v1 = 1'b1;
        @(posedge clk); #1 rst = 1'b0; mprio = 0;
        do_handshake(1'b0, who, w, ok);
        t1 = $time;
        total_cnt++; if (!ok || who != mprio || w != 0) $display("FAIL cont_first: got ok=%0d who=%0d wait=%0d want 1/%0d/0", ok, who, w, mprio); else pass_cnt++;
        mprio = 1 - who;
        #1 v0 = 1'b0;
        capture(1'b0, 4, txv, bsv, be, rs);
        total_cnt++; if (decode(txv, 4) !== 8'hA1 || grant !== 1'b0) $display("FAIL cont_byte0: got %h g=%b want a1 g=0", decode(txv, 4), grant); else pass_cnt++;
        do_handshake(1'b0, who, w, ok);
        t2 = $time;
        total_cnt++; if (!ok || who != 1 || (t2 - t1) != 410) $display("FAIL cont_second: got ok=%0d who=%0d gap=%0t want 1/1/410", ok, who, t2 - t1); else pass_cnt++;
        mprio = 1 - who;
        #1 v1 = 1'b0;
        capture(1'b0, 4, txv, bsv, be, rs);
        total_cnt++; if (txv !== exp_wave(8'hB2, 4) || grant !== 1'b1) $display("FAIL cont_byte1: got %h g=%b want %h g=1", txv, grant, exp_wave(8'hB2, 4)); else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [7:0] b0 [6];
        logic [7:0] b1 [6];
        int i0, i1, who, w, exp_who; bit ok;
        logic [7:0] sent;
        logic [39:0] txv, bsv; logic be, rs;
        for (int i = 0; i < 6; i++) begin
            b0[i] = 8'($urandom_range(0, 255));
            b1[i] = 8'($urandom_range(0, 255));
        end
        i0 = 0; i1 = 0;
        d0 = b0[0]; d1 = b1[0]; v0 = 1'b1; v1 = 1'b1;
        for (int n = 0; n < 12; n++) begin
            exp_who = (v0 && v1) ? mprio : (v0 ? 0 : 1);
            sent = (exp_who == 0) ? b0[i0] : b1[i1];
            do_handshake(1'b0, who, w, ok);
            total_cnt++; if (!ok || who != exp_who) $display("FAIL fair_grant%0d: got ok=%0d who=%0d want %0d", n, ok, who, exp_who); else pass_cnt++;
            mprio = 1 - exp_who;
            #1;
            if (who == 0) begin
                i0++;
                if (i0 < 6) d0 = b0[i0]; else v0 = 1'b0;
            end else begin
                i1++;
                if (i1 < 6) d1 = b1[i1]; else v1 = 1'b0;
            end
            capture(1'b0, 4, txv, bsv, be, rs);
            total_cnt++; if (txv !== exp_wave(sent, 4) || grant !== 1'(exp_who)) $display("FAIL fair_frame%0d: got %h g=%b want %h g=%0d", n, txv, grant, exp_wave(sent, 4), exp_who); else pass_cnt++;
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_ignored();
        int who, w; bit ok;
        logic [7:0] b;
        logic [39:0] txv, bsv; logic be, rs;
        b = 8'($urandom_range(0, 255));
        d0 = b; v0 = 1'b1;
        do_handshake(1'b0, who, w, ok);
        total_cnt++; if (!ok || who != 0) $display("FAIL ign_hs: got ok=%0d who=%0d want 1/0", ok, who); else pass_cnt++;
        mprio = 1;
        #1 v0 = 1'b0;
        fork
            capture(1'b0, 4, txv, bsv, be, rs);
            begin
                repeat (38) begin
                    @(posedge clk);
                    #1;
                    v1 = 1'($urandom_range(0, 1));
                    d1 = 8'($urandom_range(0, 255));
                    d0 = 8'($urandom_range(0, 255));
                end
                v1 = 1'b0;
            end
        join
        total_cnt++; if (txv !== exp_wave(b, 4)) $display("FAIL ign_wave: got %h want %h", txv, exp_wave(b, 4)); else pass_cnt++;
        total_cnt++; if (rs !== 1'b0 || grant !== 1'b0) $display("FAIL ign_ready: got rdy=%b g=%b want 0/0", rs, grant); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int who, w; bit ok;
        logic [39:0] txv, bsv; logic be, rs;
        d0 = 8'($urandom_range(0, 255)) & 8'hF3; v0 = 1'b1;
        do_handshake(1'b0, who, w, ok);
        total_cnt++; if (!ok || who != 0) $display("FAIL mid_hs: got ok=%0d who=%0d want 1/0", ok, who); else pass_cnt++;
        #1 v0 = 1'b0;
        repeat (17) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL mid_abort: got tx=%b busy=%b want 1/0", tx, busy); else pass_cnt++;
        d1 = 8'h0F; v1 = 1'b1;
        #1;
        total_cnt++; if ({r0, r1} !== 2'b00) $display("FAIL mid_ready: got %b want 00", {r0, r1}); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (grant !== 1'b0 || tx !== 1'b1) $display("FAIL mid_hold: got g=%b tx=%b want 0/1", grant, tx); else pass_cnt++;
        @(posedge clk); #1 rst = 1'b0; mprio = 0;
        do_handshake(1'b0, who, w, ok);
        total_cnt++; if (!ok || who != 1 || w != 0) $display("FAIL mid_rehs: got ok=%0d who=%0d wait=%0d want 1/1/0", ok, who, w); else pass_cnt++;
        mprio = 0;
        #1 v1 = 1'b0;
        capture(1'b0, 4, txv, bsv, be, rs);
        total_cnt++; if (txv !== exp_wave(8'h0F, 4) || grant !== 1'b1) $display("FAIL mid_frame: got %h g=%b want %h g=1", txv, grant, exp_wave(8'h0F, 4)); else pass_cnt++;
    endtask

    task automatic test_truncation();
        int who, w; bit ok;
        logic [7:0] b;
        logic [39:0] txv, bsv; logic be, rs;
        for (int n = 0; n < 2; n++) begin
            b = (n == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            d0_3 = b; v0_3 = 1'b1;
            do_handshake(1'b1, who, w, ok);
            total_cnt++; if (!ok || who != 0) $display("FAIL trunc_hs%0d: got ok=%0d who=%0d want 1/0", n, ok, who); else pass_cnt++;
            #1 v0_3 = 1'b0;
            capture(1'b1, 3, txv, bsv, be, rs);
            total_cnt++; if (txv !== exp_wave(b, 3)) $display("FAIL trunc_wave%0d: got %h want %h", n, txv, exp_wave(b, 3)); else pass_cnt++;
            total_cnt++; if (bsv !== ones(30) || be !== 1'b0) $display("FAIL trunc_busy%0d: got %h/%b want %h/0", n, bsv, be, ones(30)); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_ignored();
        test_reset_mid();
        test_truncation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
